// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: execute-stage control-flow controller.
// Owns the NZCV flags, merges ARM/RISC-V branch decisions into one PC
// redirect with matching flushes, sequences ARM non-branch R15 writes
// (fetch held until writeback delivers the new PC), and counts redirects.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no R15 write in flight
// PEND_E | R15 writer sits in E, waiting for its condition result
// PEND_M | R15 writer passed its condition, now in M
// PEND_W | R15 writer in W, PC mux loads ResultW this cycle
module pc_flow_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IsArmE,
  input  logic             BranchTakenE,
  input  logic             RVPCSrcE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             StallD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       FlagsNext,
  output logic [3:0]       FlagsE,
  output logic             RedirectE,
  output logic             FlushDBr,
  output logic             FlushEBr,
  output logic             StallFPc,
  output logic             PcWrPending,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND_E = 2'd1,
    PEND_M = 2'd2,
    PEND_W = 2'd3
  } pc_state_t;

  pc_state_t state, state_nxt;
  logic      redirect_raw;
  logic      pending;

  // Pick the branch decision of whichever ISA owns the E-stage instruction.
  always_comb begin
    redirect_raw = IsArmE ? BranchTakenE : RVPCSrcE;
  end

  // Redirect and flush outputs are purely combinational so fetch reacts this cycle.
  always_comb begin
    pending     = (state != IDLE);
    RedirectE   = redirect_raw & ~StallE & ~FlushE;
    FlushEBr    = RedirectE;
    FlushDBr    = RedirectE | pending;
    StallFPc    = pending | (PCSrcD & ~RedirectE);
    PcWrPending = pending;
  end

  // R15-write FSM next state; a redirect in E suppresses a new R15 writer in D.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (PCSrcD & ~StallD & ~RedirectE) state_nxt = PEND_E;
      end
      PEND_E: begin
        if (FlushE)      state_nxt = IDLE;
        else if (StallE) state_nxt = PEND_E;
        else if (PCSrcE) state_nxt = PEND_M;
        else             state_nxt = IDLE;
      end
      PEND_M:  state_nxt = PEND_W;
      PEND_W:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register; reset mid-sequence drops any pending fetch hold.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NZCV register, held while E is stalled.
  always_ff @(posedge clk) begin
    if (reset)        FlagsE <= 4'b0000;
    else if (!StallE) FlagsE <= FlagsNext;
  end

  // Wrapping count of taken redirects for performance monitoring.
  always_ff @(posedge clk) begin
    if (reset)          TakenCount <= '0;
    else if (RedirectE) TakenCount <= TakenCount + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Execute-stage control-flow controller for the combined ARM/RISC-V pipeline. It owns the NZCV flags register that feeds condition evaluation, turns the resolved branch decisions of both ISAs into one PC redirect plus the matching pipeline flushes, and sequences ARM non-branch writes to R15 so that fetch is held until the new PC arrives from writeback. It also keeps a wrapping count of taken redirects for performance monitoring.

## Interface
- CNT_W, 16, width of the taken-redirect counter
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- IsArmE  in  1  instruction in E is ARM (1) or RISC-V (0)
- BranchTakenE  in  1  ARM branch in E, condition passed
- RVPCSrcE  in  1  RISC-V jump, or branch taken, in E
- PCSrcD  in  1  ARM non-branch instruction in D writes R15
- PCSrcE  in  1  that instruction in E, condition passed
- StallD  in  1  decode stage held
- StallE  in  1  execute stage held
- FlushE  in  1  external flush of E (hazard unit)
- FlagsNext  in  4  next NZCV value, already write-masked by condition logic
- FlagsE  out  4  registered NZCV {N,Z,C,V}
- RedirectE  out  1  PC mux selects the E-stage target this cycle
- FlushDBr  out  1  flush D stage
- FlushEBr  out  1  flush E stage
- StallFPc  out  1  hold fetch for a pending R15 write
- PcWrPending  out  1  an R15 write is in flight in E, M or W
- TakenCount  out  CNT_W  taken redirects, wraps modulo 2^CNT_W

## Operation
- Flags register: FlagsE <= FlagsNext when ~StallE. It holds when StallE=1. Reset value is 4'b0000.
- Redirect:
  - raw = IsArmE ? BranchTakenE : RVPCSrcE.
  - RedirectE = raw & ~StallE & ~FlushE. It is combinational.
  - FlushDBr = RedirectE | (state != IDLE).
  - FlushEBr = RedirectE.
- R15-write FSM, states IDLE, PEND_E, PEND_M, PEND_W:
  - IDLE: if PCSrcD & ~StallD & ~RedirectE, go to PEND_E. Otherwise stay.
  - PEND_E:
    - if FlushE, go to IDLE (cancelled);
    - else if StallE, stay;
    - else if PCSrcE, go to PEND_M;
    - else go to IDLE (condition failed).
  - PEND_M: go to PEND_W unconditionally (M and W never stall).
  - PEND_W: go to IDLE. The W-stage PC mux loads ResultW this cycle.
- StallFPc = (state != IDLE) | (PCSrcD & ~RedirectE).
- PcWrPending = (state != IDLE).
- Priority:
  - A redirect in E beats a PCSrcD in D. D is flushed and the FSM stays IDLE.
  - A redirect cannot coexist with PEND_E, because the instruction in E is the R15 writer.
- Counter: TakenCount increments by 1 when RedirectE=1. It wraps from all-ones to 0.
- Reset effects:
  - FSM goes to IDLE.
  - FlagsE = 0.
  - TakenCount = 0.
  - All combinational outputs are qualified only by inputs and state, so they read 0 while inputs are 0.
- Reset mid-sequence (any PEND_* state) returns to IDLE on the next edge. No stale stall remains.

## Timing
- FlagsE updates one cycle after FlagsNext is presented, provided StallE=0.
- RedirectE, FlushDBr, FlushEBr and StallFPc respond in the same cycle as their inputs (zero latency).
- R15 write sequence:
  - D-cycle t: StallFPc=1.
  - PEND_E at t+1, PEND_M at t+2, PEND_W at t+3, IDLE at t+4.
  - Fetch is held for cycles t to t+3, so for 4 cycles with no E stall.
  - Each StallE cycle in PEND_E adds one cycle.
- Condition failed in PEND_E: stall releases the following cycle. The total is 2 cycles.
- TakenCount is visible one cycle after the redirect.

## Test plan
- Reset, then FlagsNext=4'b1010 with StallE=0 → FlagsE=4'b1010 next cycle. With StallE=1 and FlagsNext=4'b0101, FlagsE stays 4'b1010.
- IsArmE=0, RVPCSrcE=1, BranchTakenE=0 → RedirectE=FlushDBr=FlushEBr=1 and TakenCount 0→1. Repeating with IsArmE=1 → RedirectE=0.
- PCSrcD=1 at cycle 0, then PCSrcE=1 → StallFPc=1 for cycles 0–3, state sequence PEND_E/PEND_M/PEND_W, IDLE at cycle 4, PcWrPending=0 at cycle 4.
- PCSrcD=1, then PCSrcE=0 in PEND_E → IDLE at cycle 2, StallFPc=0 at cycle 2. A separate run with FlushE=1 in PEND_E behaves identically.
- BranchTakenE=1 (ARM) and PCSrcD=1 in the same cycle → RedirectE=1, StallFPc=0, FSM stays IDLE.
- CNT_W=4 with 17 redirects → TakenCount=1. Reset asserted while in PEND_M → IDLE, StallFPc=0 and TakenCount=0 the next cycle.
